// File: rtl/bht_update_unit.sv
// Branch history table of 2-bit saturating counters, trained by resolved branches, with a flush sweep.
// Optional macro BHT_UPDATE_BYPASS_EN forwards a same-cycle update to a lookup of the same index.
module bht_update_unit #(
  parameter int unsigned VLEN       = 39,
  parameter int unsigned NR_ENTRIES = 64,
  localparam int unsigned IDX_BITS  = $clog2(NR_ENTRIES)
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            flush_bp_i,
  input  logic            debug_mode_i,
  input  logic            lookup_valid_i,
  input  logic [VLEN-1:0] lookup_pc_i,
  output logic            lookup_valid_o,
  output logic            lookup_taken_o,
  input  logic            update_valid_i,
  input  logic [VLEN-1:0] update_pc_i,
  input  logic            update_is_branch_i,
  input  logic            update_taken_i,
  output logic            busy_o
);

  // state | meaning
  // IDLE  | normal lookup and training
  // FLUSH | sweeping the table one entry per cycle; lookups miss, updates dropped
  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] FLUSH = 1'b1;

  logic [0:0]          state_q;
  logic [IDX_BITS-1:0] sweep_idx_q;
  logic                valid_q [NR_ENTRIES];
  logic [1:0]          ctr_q   [NR_ENTRIES];

  logic [IDX_BITS-1:0] lk_idx;
  logic [IDX_BITS-1:0] upd_idx;
  logic                upd_en;
  logic [1:0]          upd_ctr;
  logic                lk_valid_d;
  logic                lk_taken_d;
  logic                unused_pc;

  // Instructions are 2-byte aligned, so pc bit 0 never selects an entry.
  assign lk_idx  = lookup_pc_i[IDX_BITS:1];
  assign upd_idx = update_pc_i[IDX_BITS:1];
  assign unused_pc = ^{lookup_pc_i[VLEN-1:IDX_BITS+1], lookup_pc_i[0],
                       update_pc_i[VLEN-1:IDX_BITS+1], update_pc_i[0]};

  assign upd_en = (state_q == IDLE) && !flush_bp_i && update_valid_i &&
                  update_is_branch_i && !debug_mode_i;
  assign busy_o = (state_q == FLUSH);

  always_comb begin
    upd_ctr = ctr_q[upd_idx];
    if (!valid_q[upd_idx]) begin
      upd_ctr = update_taken_i ? 2'b10 : 2'b01;
    end else if (update_taken_i) begin
      if (ctr_q[upd_idx] != 2'b11) upd_ctr = ctr_q[upd_idx] + 2'b01;
    end else begin
      if (ctr_q[upd_idx] != 2'b00) upd_ctr = ctr_q[upd_idx] - 2'b01;
    end
  end

  always_comb begin
    lk_valid_d = 1'b0;
    lk_taken_d = 1'b0;
    if (lookup_valid_i && (state_q == IDLE)) begin
      lk_valid_d = valid_q[lk_idx];
      lk_taken_d = ctr_q[lk_idx][1];
`ifdef BHT_UPDATE_BYPASS_EN
      if (upd_en && (upd_idx == lk_idx)) begin
        lk_valid_d = 1'b1;
        lk_taken_d = upd_ctr[1];
      end
`endif
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      sweep_idx_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (flush_bp_i) begin
            state_q     <= FLUSH;
            sweep_idx_q <= '0;
          end
        end
        default: begin
          // A new flush request restarts the sweep rather than extending it.
          if (flush_bp_i) begin
            sweep_idx_q <= '0;
          end else if (sweep_idx_q == IDX_BITS'(NR_ENTRIES - 1)) begin
            state_q     <= IDLE;
            sweep_idx_q <= '0;
          end else begin
            sweep_idx_q <= sweep_idx_q + 1'b1;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < NR_ENTRIES; i++) begin
        valid_q[i] <= 1'b0;
        ctr_q[i]   <= 2'b01;
      end
    end else if (state_q == FLUSH) begin
      valid_q[sweep_idx_q] <= 1'b0;
      ctr_q[sweep_idx_q]   <= 2'b01;
    end else if (upd_en) begin
      valid_q[upd_idx] <= 1'b1;
      ctr_q[upd_idx]   <= upd_ctr;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      lookup_valid_o <= 1'b0;
      lookup_taken_o <= 1'b0;
    end else begin
      lookup_valid_o <= lk_valid_d;
      lookup_taken_o <= lk_taken_d;
    end
  end

endmodule
